// File: rtl/run_detector.sv
`default_nettype none
// ============================================================================
// Module      : run_detector
// Description : Samples serial input w on every KEY0 rising edge and tracks
//               the length of the current run of identical samples. z flags
//               a run of RUN_LEN equal samples, with the polarity chosen by
//               mode = {SW3, SW2}. Rising edges of z are counted on HITS.
//               Optional macro RUN_ALT_EN: when defined, mode 11 flags
//               RUN_LEN consecutive alternating samples instead.
// Ports       : KEY0       clock (rising edge)
//               SW0        synchronous active-low reset
//               SW1        serial input w
//               SW2, SW3   mode[0], mode[1] (not registered)
//               LEDR[9]    z
//               LEDR[8]    last sampled w (0 while idle)
//               LEDR[7:0]  active counter, zero-extended
//               HITS       number of z rising events, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 3,
    parameter int HIT_W   = 8
) (
    input  logic             KEY0,
    input  logic             SW0,
    input  logic             SW1,
    input  logic             SW2,
    input  logic             SW3,
    output logic [9:0]       LEDR,
    output logic [HIT_W-1:0] HITS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_run_max = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [CNT_W-1:0]   w_run_nxt;
    logic               r_last_w;
    logic               w_last_nxt;
    logic               r_z_d;
    logic [HIT_W-1:0]   r_hits;
    logic [1:0]         w_mode;
    logic               w_in_run;
    logic               w_same;
    logic               w_run_full;
    logic               w_z;
    logic [7:0]         w_cnt_disp;

    assign w_mode   = {SW3, SW2};
    assign w_in_run = (r_state == RUN0) || (r_state == RUN1);
    // last_w always mirrors the polarity of the current run, so it doubles as
    // the comparison reference for the incoming sample.
    assign w_same   = w_in_run && (SW1 == r_last_w);

    // ------------------------------------------------------------------
    // Next-state / next-counter logic. Any non-matching sample (including
    // the first one after reset, or an unused state encoding) starts a new
    // run of length 1 in the sampled polarity.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_last_nxt  = r_last_w;
        if (w_same) begin
            w_run_nxt = (r_run_cnt == c_run_max) ? c_run_max : r_run_cnt + c_one;
        end else begin
            w_state_nxt = SW1 ? RUN1 : RUN0;
            w_run_nxt   = c_one;
            w_last_nxt  = SW1;
        end
    end

    always_ff @(posedge KEY0) begin
        if (!SW0) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_last_w  <= 1'b0;
            r_z_d     <= 1'b0;
            r_hits    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_last_w  <= w_last_nxt;
            r_z_d     <= w_z;
            if (w_z && !r_z_d) begin
                r_hits <= r_hits + HIT_W'(1);
            end
        end
    end

    assign w_run_full = (r_run_cnt == c_run_max);

`ifdef RUN_ALT_EN
    // Alternation counter: grows on every polarity change, drops back to 1
    // on a repeated sample. The first sample after reset counts as 1.
    logic [CNT_W-1:0] r_alt_cnt;
    logic [CNT_W-1:0] w_alt_nxt;
    logic             w_alt_full;

    always_comb begin
        w_alt_nxt = c_one;
        if (w_in_run && !w_same) begin
            w_alt_nxt = (r_alt_cnt == c_run_max) ? c_run_max : r_alt_cnt + c_one;
        end
    end

    always_ff @(posedge KEY0) begin
        if (!SW0) begin
            r_alt_cnt <= '0;
        end else begin
            r_alt_cnt <= w_alt_nxt;
        end
    end

    assign w_alt_full = (r_alt_cnt == c_run_max);
`endif

    // z depends only on registered state and the live mode inputs.
    always_comb begin
        w_z = 1'b0;
        case (w_mode)
            2'b00:   w_z = w_run_full;
            2'b01:   w_z = w_run_full && (r_state == RUN1);
            2'b10:   w_z = w_run_full && (r_state == RUN0);
`ifdef RUN_ALT_EN
            default: w_z = w_alt_full;
`else
            default: w_z = w_run_full;
`endif
        endcase
    end

    always_comb begin
        w_cnt_disp = 8'(r_run_cnt);
`ifdef RUN_ALT_EN
        if (w_mode == 2'b11) begin
            w_cnt_disp = 8'(r_alt_cnt);
        end
`endif
    end

    assign LEDR = {w_z, r_last_w, w_cnt_disp};
    assign HITS = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_run_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_detector
// Description : Directed self-checking bench for run_detector with
//               RUN_LEN=4, CNT_W=3, HIT_W=8. Expectations for mode 11 follow
//               the RUN_ALT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_detector;

    logic       KEY0;
    logic       SW0;
    logic       SW1;
    logic       SW2;
    logic       SW3;
    logic [9:0] LEDR;
    logic [7:0] HITS;

    int n_total;
    int n_pass;

    run_detector #(
        .RUN_LEN (4),
        .CNT_W   (3),
        .HIT_W   (8)
    ) u_dut (
        .KEY0 (KEY0),
        .SW0  (SW0),
        .SW1  (SW1),
        .SW2  (SW2),
        .SW3  (SW3),
        .LEDR (LEDR),
        .HITS (HITS)
    );

    initial KEY0 = 1'b0;
    always #5 KEY0 = ~KEY0;

    // Drive w, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic w);
        SW1 = w;
        @(posedge KEY0);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        {SW3, SW2} = m;
        #1;
    endtask

    task automatic do_reset();
        SW0 = 1'b0;
        step(1'b1);
        SW0 = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (LEDR !== 10'd0) $display("FAIL reset_ledr: got %b expected %b", LEDR, 10'd0);
        else n_pass++;
        n_total++;
        if (HITS !== 8'd0) $display("FAIL reset_hits: got %0d expected 0", HITS);
        else n_pass++;
    endtask

    task automatic test_run_hold();
        set_mode(2'b00);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1);
            n_total++;
            if (LEDR[7:0] !== 8'(i) || LEDR[9] !== (i == 4))
                $display("FAIL hold_count%0d: got cnt=%0d z=%b expected cnt=%0d z=%b",
                         i, LEDR[7:0], LEDR[9], i, (i == 4));
            else n_pass++;
        end
        n_total++;
        if (LEDR[8] !== 1'b1 || HITS !== 8'd0)
            $display("FAIL hold_w_hits0: got w=%b hits=%0d expected w=1 hits=0", LEDR[8], HITS);
        else n_pass++;
        step(1'b1);
        n_total++;
        if (HITS !== 8'd1) $display("FAIL hold_hit1: got %0d expected 1", HITS);
        else n_pass++;
        for (int i = 0; i < 9; i++) step(1'b1);
        n_total++;
        if (LEDR !== 10'b11_0000_0100 || HITS !== 8'd1)
            $display("FAIL hold_sat: got ledr=%b hits=%0d expected ledr=1100000100 hits=1", LEDR, HITS);
        else n_pass++;
        step(1'b0);
        n_total++;
        if (LEDR !== 10'b00_0000_0001)
            $display("FAIL hold_flip: got %b expected 0000000001", LEDR);
        else n_pass++;
    endtask

    task automatic test_mode01();
        do_reset();
        set_mode(2'b01);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0);
            n_total++;
            if (LEDR[9] !== 1'b0) $display("FAIL m01_zero_run%0d: got z=%b expected 0", i, LEDR[9]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        n_total++;
        if (LEDR !== 10'b11_0000_0100 || HITS !== 8'd0)
            $display("FAIL m01_one_run: got ledr=%b hits=%0d expected ledr=1100000100 hits=0", LEDR, HITS);
        else n_pass++;
        step(1'b1);
        n_total++;
        if (HITS !== 8'd1) $display("FAIL m01_hit: got %0d expected 1", HITS);
        else n_pass++;
    endtask

    task automatic test_mode_change();
        do_reset();
        set_mode(2'b00);
        for (int i = 0; i < 5; i++) step(1'b1);
        n_total++;
        if (LEDR[9] !== 1'b1 || HITS !== 8'd1)
            $display("FAIL mc_start: got z=%b hits=%0d expected z=1 hits=1", LEDR[9], HITS);
        else n_pass++;
        set_mode(2'b10);
        n_total++;
        if (LEDR !== 10'b01_0000_0100)
            $display("FAIL mc_gate_off: got %b expected 0100000100", LEDR);
        else n_pass++;
        step(1'b1);
        set_mode(2'b00);
        n_total++;
        if (LEDR[9] !== 1'b1 || HITS !== 8'd1)
            $display("FAIL mc_gate_on: got z=%b hits=%0d expected z=1 hits=1", LEDR[9], HITS);
        else n_pass++;
        step(1'b1);
        n_total++;
        if (HITS !== 8'd2) $display("FAIL mc_hit: got %0d expected 2", HITS);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        set_mode(2'b00);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        n_total++;
        if (LEDR[7:0] !== 8'd3 || HITS === 8'd0)
            $display("FAIL rm_pre: got cnt=%0d hits=%0d expected cnt=3 hits=2", LEDR[7:0], HITS);
        else n_pass++;
        SW0 = 1'b0;
        step(1'b0);
        n_total++;
        if (LEDR !== 10'd0 || HITS !== 8'd0)
            $display("FAIL rm_reset: got ledr=%b hits=%0d expected ledr=0 hits=0", LEDR, HITS);
        else n_pass++;
        SW0 = 1'b1;
        step(1'b0);
        n_total++;
        if (LEDR !== 10'b00_0000_0001)
            $display("FAIL rm_restart: got %b expected 0000000001", LEDR);
        else n_pass++;
    endtask

    task automatic test_alt();
        logic [7:0] exp_cnt;
        logic       exp_z;
        do_reset();
        set_mode(2'b11);
        for (int i = 1; i <= 4; i++) begin
            step(1'((i - 1) % 2));
`ifdef RUN_ALT_EN
            exp_cnt = 8'(i);
            exp_z   = (i == 4);
`else
            exp_cnt = 8'd1;
            exp_z   = 1'b0;
`endif
            n_total++;
            if (LEDR[7:0] !== exp_cnt || LEDR[9] !== exp_z)
                $display("FAIL alt_step%0d: got cnt=%0d z=%b expected cnt=%0d z=%b",
                         i, LEDR[7:0], LEDR[9], exp_cnt, exp_z);
            else n_pass++;
        end
        step(1'b1);
`ifdef RUN_ALT_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd2;
`endif
        n_total++;
        if (LEDR[7:0] !== exp_cnt || LEDR[9] !== 1'b0)
            $display("FAIL alt_break: got cnt=%0d z=%b expected cnt=%0d z=0", LEDR[7:0], LEDR[9], exp_cnt);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        SW0 = 1'b0;
        SW1 = 1'b0;
        SW2 = 1'b0;
        SW3 = 1'b0;
        test_reset();
        test_run_hold();
        test_mode01();
        test_mode_change();
        test_reset_midrun();
        test_alt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the fixed four-in-a-row FSM lab block.
- Samples serial input w on every clock edge and tracks the run length of identical consecutive samples.
- Flags z when the run reaches RUN_LEN; a mode select chooses which polarity counts.
- Counts detection events for display; sits directly on board switches, key-clock and LEDs.

Parameters:
- RUN_LEN, 4, consecutive equal samples needed to assert z; legal range 2..255.
- CNT_W, 3, run counter width; must satisfy 2^CNT_W > RUN_LEN and CNT_W <= 8.
- HIT_W, 8, detection event counter width.

Ports:
- KEY0  in  1  clock; all state updates on its rising edge.
- SW0  in  1  reset, synchronous, active-low.
- SW1  in  1  serial input w.
- SW2  in  1  mode[0].
- SW3  in  1  mode[1].
- LEDR  out  10  [9]=z, [8]=last sampled w, [7:0]=active counter zero-extended.
- HITS  out  HIT_W  number of z rising events.

Behaviour:
- Reset: SW0=0 at a rising KEY0 sets the following. Reset has priority over all other activity, including mid-run.
  - state IDLE; run_cnt=0, alt_cnt=0, last_w=0, z_d=0, HITS=0.
  - Resulting outputs: LEDR=10'b0, HITS=0.
- States:
  - IDLE: no sample taken since reset.
  - RUN0: last sample was 0.
  - RUN1: last sample was 1.
- Transitions, evaluated each rising edge with SW0=1 and sampled w:
  - From IDLE: go to RUN(w); run_cnt=1; alt_cnt=1; last_w=w.
  - From RUNx, w==x: stay; run_cnt=min(run_cnt+1, RUN_LEN); alt_cnt=1.
  - From RUNx, w!=x: go to RUN(w); run_cnt=1; alt_cnt=min(alt_cnt+1, RUN_LEN); last_w=w.
- Counters saturate at RUN_LEN and never wrap. A long run holds z high continuously.
- mode = {SW3, SW2}:
  - 00: z = (run_cnt==RUN_LEN), either polarity.
  - 01: z = (run_cnt==RUN_LEN) & RUN1.
  - 10: z = (run_cnt==RUN_LEN) & RUN0.
  - 11: see Optional Feature.
- z is Moore-style: a combinational function of registered state and mode, with no dependence on the current w.
  - z asserts immediately after the RUN_LEN-th consecutive equal edge. RUN_LEN=4 gives the classic behaviour: high after the 4th edge.
- Mode is not registered. Changing it mid-run re-gates z in the same cycle, and counters are unaffected.
- LEDR[7:0] shows alt_cnt in mode 11 with RUN_ALT_EN defined, otherwise run_cnt.
- LEDR[8] = last_w; it reads 0 in IDLE.
- HITS:
  - z_d <= z on every edge.
  - HITS <= HITS+1 on an edge where z==1 and z_d==0, i.e. one edge after z rises.
  - Wraps modulo 2^HIT_W.
  - A z rise caused by a mode change counts as a hit.
- A polarity flip while saturated drops z after that edge and restarts the count at 1; no minimum gap applies.

Optional Feature:
- Macro RUN_ALT_EN.
- Defined: mode 11 gives z = (alt_cnt==RUN_LEN), i.e. RUN_LEN consecutive alternating samples (0101... or 1010...). LEDR[7:0] shows alt_cnt in this mode.
- Not defined: alt_cnt logic is absent and mode 11 behaves exactly as mode 00.

Test Plan (RUN_LEN=4, CNT_W=3, HIT_W=8):
- Reset, mode 00, SW1=1 held for 4 edges -> LEDR[7:0] counts 1,2,3,4; LEDR[9]=1 after the 4th edge; LEDR[8]=1; HITS=1 one edge later.
- Continue SW1=1 for 10 more edges -> count stays 4, z stays 1, HITS stays 1. Then SW1=0 for one edge -> z=0, count=1, LEDR[8]=0.
- Mode 01, four 0s then four 1s -> z stays 0 during the 0-run; z=1 after the 4th 1; HITS increments once.
- Mode 00 with z=1 on a 1-run, switch to mode 10 -> z=0 that cycle. Switch back to 00 -> z=1 and HITS increments on the next edge.
- Assert SW0=0 mid-run at count 3 -> after that edge LEDR=0 and HITS=0. Release, then one SW1=0 edge -> count=1, LEDR[8]=0.
- With RUN_ALT_EN defined, mode 11, w=0,1,0,1 -> LEDR[7:0]=1,2,3,4 and z=1 after the 4th edge. Then w=1 -> alt_cnt=1, z=0. Without the macro, the same stimulus gives z=0 and LEDR[7:0] shows run_cnt.
